// File: rtl/weight_init_ctrl_if.sv
// Weight-RAM write port plus external weight stream handshake.
// master = initialiser side, slave = RAM/stream side.
interface weight_init_ctrl_if #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 7,
    parameter int BANK_W = 2
);
    logic [DATA_W-1:0]        ext_data;
    logic                     ext_valid;
    logic                     ext_ready;
    logic                     wr_en;
    logic [BANK_W-1:0]        wr_bank;
    logic [ADDR_W-1:0]        wr_addr;
    logic signed [DATA_W-1:0] wr_data;

    modport master (
        input  ext_data, ext_valid,
        output ext_ready, wr_en, wr_bank, wr_addr, wr_data
    );

    modport slave (
        output ext_data, ext_valid,
        input  ext_ready, wr_en, wr_bank, wr_addr, wr_data
    );
endinterface

// File: rtl/weight_init_ctrl.sv
// Multi-bank weight RAM initialiser: LFSR, constant or external stream.
// Writes are issued in FILL and appear on the registered write port next cycle.
module weight_init_ctrl #(
    parameter int DATA_W    = 10,
    parameter int DEPTH     = 65,
    parameter int ADDR_W    = 7,
    parameter int NUM_BANKS = 4,
    parameter int BANK_W    = 2,
    parameter int LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] SEED = LFSR_W'(16'hACE1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [1:0]               mode,
    input  logic [3:0]               shift,
    input  logic [DATA_W-1:0]        const_val,
    input  logic                     seed_load,
    input  logic [LFSR_W-1:0]        seed_in,
    output logic                     busy,
    output logic                     done,
    output logic [BANK_W+ADDR_W-1:0] word_count,
    weight_init_ctrl_if.master       bus
);
    localparam int CNT_W = BANK_W + ADDR_W;
    localparam logic [CNT_W-1:0]  TOTAL = CNT_W'(NUM_BANKS * DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [LFSR_W-1:0] MASK = LFSR_W'(16'hB400);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]               state_q, state_d;
    logic [1:0]               mode_q;
    logic [3:0]               shift_q;
    logic [DATA_W-1:0]        const_q;
    logic [LFSR_W-1:0]        lfsr_q, lfsr_step;
    logic [BANK_W-1:0]        bank_q;
    logic [ADDR_W-1:0]        addr_q;
    logic                     full, ready, issue;
    logic signed [DATA_W-1:0] lfsr_word, nxt_data;
    logic [3:0]               shift_sat;

    assign busy          = (state_q == FILL);
    assign bus.ext_ready = ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; FILL lingers one cycle after the final issue
    // so the last write is still shown while busy.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = FILL;
            FILL: begin
                if (abort)     state_d = IDLE;
                else if (full) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Write issue decision and data source selection
    always_comb begin
        full      = (word_count == TOTAL);
        ready     = (state_q == FILL) && !full && !abort;
        issue     = ready && ((mode_q != 2'd2) || bus.ext_valid);
        lfsr_word = $signed(lfsr_q[DATA_W-1:0]) >>> shift_q;
        lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ MASK) : (lfsr_q >> 1);
        shift_sat = (int'(shift) >= DATA_W) ? 4'(DATA_W - 1) : shift;
        case (mode_q)
            2'd1:    nxt_data = $signed(const_q);
            2'd2:    nxt_data = $signed(bus.ext_data);
            default: nxt_data = lfsr_word;
        endcase
    end

    // Datapath: latched settings, LFSR, address sequencing, write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q      <= '0;
            shift_q     <= '0;
            const_q     <= '0;
            lfsr_q      <= SEED;
            bank_q      <= '0;
            addr_q      <= '0;
            word_count  <= '0;
            done        <= 1'b0;
            bus.wr_en   <= 1'b0;
            bus.wr_bank <= '0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
        end else begin
            bus.wr_en <= issue;
            if (state_q == IDLE && start) begin
                mode_q     <= (mode == 2'd3) ? 2'd0 : mode;
                shift_q    <= shift_sat;
                const_q    <= const_val;
                bank_q     <= '0;
                addr_q     <= '0;
                word_count <= '0;
                done       <= 1'b0;
            end else if (state_q == IDLE && seed_load) begin
                lfsr_q <= (seed_in == '0) ? SEED : seed_in;
            end
            if (issue) begin
                bus.wr_bank <= bank_q;
                bus.wr_addr <= addr_q;
                bus.wr_data <= nxt_data;
                word_count  <= word_count + CNT_W'(1);
                if (addr_q == LAST_ADDR) begin
                    addr_q <= '0;
                    bank_q <= bank_q + BANK_W'(1);
                end else begin
                    addr_q <= addr_q + ADDR_W'(1);
                end
                if (mode_q == 2'd0) lfsr_q <= lfsr_step;
            end
            if (state_q == FILL && state_d == DONE) done <= 1'b1;
        end
    end
endmodule
